// File: rtl/ping_pkg.sv
// rtl/ping_pkg.sv - shared widths, sentinel and FSM states for the ping sampler
// Contents: CM_W/BCD_W widths, ERR_CM sentinel, cm_t/bcd_t types, sampler FSM state enum.
package ping_pkg;

    localparam int unsigned CM_W  = 10;
    localparam int unsigned BCD_W = 4;

    // Value the ping block reports when its own echo timer expires.
    localparam logic [CM_W-1:0] ERR_CM = 10'd255;

    typedef logic [CM_W-1:0]  cm_t;
    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        CONVERT,
        RELEASE,
        UPDATE
    } sampler_state_e;

endpackage

// File: rtl/bcd3_to_bin.sv
// rtl/bcd3_to_bin.sv - combinational 3-digit BCD to 10-bit binary converter
// Ports: hundreds/tens/digits (BCD in), value (10-bit binary, modulo 1024), bad_digit (any digit > 9).
module bcd3_to_bin
    import ping_pkg::*;
(
    input  bcd_t hundreds,
    input  bcd_t tens,
    input  bcd_t digits,
    output cm_t  value,
    output logic bad_digit
);

    // Arithmetic is done at the output width so illegal digits simply wrap.
    assign value = cm_t'(hundreds) * 10'd100 + cm_t'(tens) * 10'd10 + cm_t'(digits);

    assign bad_digit = (hundreds > 4'd9) | (tens > 4'd9) | (digits > 4'd9);

endmodule

// File: rtl/ping_sampler.sv
// rtl/ping_sampler.sv - periodic ping requester with error rejection and 4-sample average
// Ports: clk, reset (async, active-high), enable; req/done handshake with the ping block;
//        cm_hundreds/cm_tens/cm_digits BCD result in; sample_cm (raw), distance_cm (average),
//        valid (one-cycle strobe), out_of_range, err_count (saturating), busy (FSM not idle).
module ping_sampler
    import ping_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES   = 1500000,
    parameter int unsigned WATCHDOG_CYCLES = 300000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       req,
    input  logic       done,
    input  bcd_t       cm_digits,
    input  bcd_t       cm_tens,
    input  bcd_t       cm_hundreds,
    output cm_t        sample_cm,
    output cm_t        distance_cm,
    output logic       valid,
    output logic       out_of_range,
    output logic [7:0] err_count,
    output logic       busy
);

    localparam int unsigned PER_W = $clog2(PERIOD_CYCLES);
    localparam int unsigned WD_W  = $clog2(WATCHDOG_CYCLES);

    sampler_state_e    state_q, state_d;
    logic [PER_W-1:0]  period_q, period_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    bcd_t              hun_q, hun_d, ten_q, ten_d, dig_q, dig_d;
    cm_t               sample_q, sample_d;
    logic              err_q, err_d;
    logic [3:0][CM_W-1:0] hist_q, hist_d;
    logic              hist_vld_q, hist_vld_d;
    cm_t               dist_q, dist_d;
    logic              valid_q, valid_d;
    logic              oor_q, oor_d;
    logic [7:0]        errcnt_q, errcnt_d;

    logic              tick;
    logic [11:0]       sum;
    cm_t               conv_value;
    logic              conv_bad;

    bcd3_to_bin u_conv (
        .hundreds  (hun_q),
        .tens      (ten_q),
        .digits    (dig_q),
        .value     (conv_value),
        .bad_digit (conv_bad)
    );

    assign tick     = (period_q == PER_W'(PERIOD_CYCLES - 1));
    assign period_d = tick ? '0 : period_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        wdog_d     = wdog_q;
        hun_d      = hun_q;
        ten_d      = ten_q;
        dig_d      = dig_q;
        sample_d   = sample_q;
        err_d      = err_q;
        hist_d     = hist_q;
        hist_vld_d = hist_vld_q;
        dist_d     = dist_q;
        oor_d      = oor_q;
        errcnt_d   = errcnt_q;
        valid_d    = 1'b0;
        sum        = '0;

        case (state_q)
            IDLE: begin
                wdog_d = '0;
                err_d  = 1'b0;
                // Ticks seen outside IDLE are simply lost; a stale done blocks a new request.
                if (tick && enable && !done) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (done) begin
                    hun_d   = cm_hundreds;
                    ten_d   = cm_tens;
                    dig_d   = cm_digits;
                    state_d = CONVERT;
                end else if (wdog_q == WD_W'(WATCHDOG_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = RELEASE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            CONVERT: begin
                sample_d = conv_value;
                err_d    = conv_bad | (conv_value == ERR_CM);
                state_d  = RELEASE;
            end
            RELEASE: begin
                // Hold req low until the ping block has dropped done so it re-arms.
                if (!done) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                valid_d = 1'b1;
                state_d = IDLE;
                if (err_q) begin
                    oor_d = 1'b1;
                    if (errcnt_q != 8'hFF) begin
                        errcnt_d = errcnt_q + 8'd1;
                    end
                end else begin
                    oor_d = 1'b0;
                    // First good reading fills the whole window so the average starts at it.
                    if (!hist_vld_q) begin
                        hist_d = {4{sample_q}};
                    end else begin
                        hist_d = {hist_q[2:0], sample_q};
                    end
                    hist_vld_d = 1'b1;
                    sum = 12'(hist_d[0]) + 12'(hist_d[1]) + 12'(hist_d[2]) + 12'(hist_d[3]);
                    dist_d = cm_t'(sum >> 2);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            period_q   <= '0;
            wdog_q     <= '0;
            hun_q      <= '0;
            ten_q      <= '0;
            dig_q      <= '0;
            sample_q   <= '0;
            err_q      <= 1'b0;
            hist_q     <= '0;
            hist_vld_q <= 1'b0;
            dist_q     <= '0;
            valid_q    <= 1'b0;
            oor_q      <= 1'b0;
            errcnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            wdog_q     <= wdog_d;
            hun_q      <= hun_d;
            ten_q      <= ten_d;
            dig_q      <= dig_d;
            sample_q   <= sample_d;
            err_q      <= err_d;
            hist_q     <= hist_d;
            hist_vld_q <= hist_vld_d;
            dist_q     <= dist_d;
            valid_q    <= valid_d;
            oor_q      <= oor_d;
            errcnt_q   <= errcnt_d;
        end
    end

    // req decodes straight from the state register so an async reset drops it at once.
    assign req          = (state_q == REQ);
    assign busy         = (state_q != IDLE);
    assign sample_cm    = sample_q;
    assign distance_cm  = dist_q;
    assign valid        = valid_q;
    assign out_of_range = oor_q;
    assign err_count    = errcnt_q;

endmodule
